// File: rtl/bomb_drop_ctrl.sv
// Bomb drop controller: snaps a dropped bomb to the tile grid, runs the
// frame-counted fuse, then holds the blast window.
module bomb_drop_ctrl #(
    parameter int TILE_SIZE     = 32,
    parameter int GRID_ORIGIN_X = 15,
    parameter int GRID_ORIGIN_Y = 48,
    parameter int GRID_COLS     = 19,
    parameter int GRID_ROWS     = 13,
    parameter int FUSE_FRAMES   = 90,
    parameter int BLAST_FRAMES  = 15,
    parameter int BLINK_FRAMES  = 30
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               drop_bomb,
    input  logic signed [10:0] playerTopLeftX,
    input  logic signed [10:0] playerTopLeftY,
    input  logic               chain_trigger,
    output logic signed [10:0] bombTopLeftX,
    output logic signed [10:0] bombTopLeftY,
    output logic               bomb_visible,
    output logic               fuse_blink,
    output logic               blast_active,
    output logic               explode_pulse,
    output logic               busy
);

    localparam int SHIFT = $clog2(TILE_SIZE);
    localparam int FW    = $clog2(FUSE_FRAMES + 1);
    localparam int BW    = $clog2(BLAST_FRAMES + 1);

    localparam logic signed [11:0] HALF  = 12'(TILE_SIZE / 2);
    localparam logic signed [11:0] ORG_X = 12'(GRID_ORIGIN_X);
    localparam logic signed [11:0] ORG_Y = 12'(GRID_ORIGIN_Y);
    localparam logic signed [11:0] MAX_C = 12'(GRID_COLS - 1);
    localparam logic signed [11:0] MAX_R = 12'(GRID_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE_ST,
        ARMED_ST,
        BLAST_ST
    } state_t;

    state_t            state, state_n;
    logic [FW-1:0]     fuse_cnt, fuse_n;
    logic [BW-1:0]     blast_cnt, blast_n;
    logic              drop_d;
    logic              drop_edge;
    logic              expl_n;
    logic              blink_n;
    logic signed [10:0] snap_x, snap_y;
    logic signed [10:0] bx_n, by_n;

    // Nearest tile by rounding the top-left corner, clamped to the grid.
    function automatic logic signed [10:0] snap(
        input logic signed [10:0] pos,
        input logic signed [11:0] org,
        input logic signed [11:0] lim
    );
        logic signed [11:0] v;
        logic signed [11:0] c;
        logic signed [11:0] r;
        v = {pos[10], pos} + HALF - org;
        c = v >>> SHIFT;
        if (c < 12'sd0)
            c = 12'sd0;
        else if (c > lim)
            c = lim;
        r = org + (c <<< SHIFT);
        return r[10:0];
    endfunction

    assign drop_edge = drop_bomb & ~drop_d;
    assign snap_x    = snap(playerTopLeftX, ORG_X, MAX_C);
    assign snap_y    = snap(playerTopLeftY, ORG_Y, MAX_R);

    always_comb begin
        state_n = state;
        fuse_n  = fuse_cnt;
        blast_n = blast_cnt;
        bx_n    = bombTopLeftX;
        by_n    = bombTopLeftY;
        expl_n  = 1'b0;
        unique case (state)
            IDLE_ST: begin
                if (drop_edge) begin
                    state_n = ARMED_ST;
                    fuse_n  = FW'(FUSE_FRAMES);
                    bx_n    = snap_x;
                    by_n    = snap_y;
                end
            end
            ARMED_ST: begin
                if (startOfFrame)
                    fuse_n = fuse_cnt - FW'(1);
                // Chain and fuse expiry together still give one detonation.
                if (chain_trigger ||
                    (startOfFrame && fuse_cnt == FW'(1))) begin
                    state_n = BLAST_ST;
                    blast_n = BW'(BLAST_FRAMES);
                    expl_n  = 1'b1;
                end
            end
            BLAST_ST: begin
                if (startOfFrame) begin
                    blast_n = blast_cnt - BW'(1);
                    if (blast_cnt == BW'(1))
                        state_n = IDLE_ST;
                end
            end
            default: state_n = IDLE_ST;
        endcase
        blink_n = (state_n == ARMED_ST) &&
                  (fuse_n <= FW'(BLINK_FRAMES)) && fuse_n[1];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= IDLE_ST;
            fuse_cnt      <= '0;
            blast_cnt     <= '0;
            drop_d        <= 1'b0;
            bombTopLeftX  <= '0;
            bombTopLeftY  <= '0;
            bomb_visible  <= 1'b0;
            fuse_blink    <= 1'b0;
            blast_active  <= 1'b0;
            explode_pulse <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            fuse_cnt      <= fuse_n;
            blast_cnt     <= blast_n;
            drop_d        <= drop_bomb;
            bombTopLeftX  <= bx_n;
            bombTopLeftY  <= by_n;
            bomb_visible  <= (state_n == ARMED_ST);
            fuse_blink    <= blink_n;
            blast_active  <= (state_n == BLAST_ST);
            explode_pulse <= expl_n;
            busy          <= (state_n != IDLE_ST);
        end
    end

endmodule

// File: tb/tb_bomb_drop_ctrl.sv
// Bench for bomb_drop_ctrl: directed scenarios plus random traffic
// against a frame-counting reference model.
module tb_bomb_drop_ctrl;

    localparam int FUSE  = 90;
    localparam int BLAST = 15;
    localparam int BLINK = 30;

    logic               clk = 1'b0;
    logic               resetN = 1'b0;
    logic               startOfFrame = 1'b0;
    logic               drop_bomb = 1'b0;
    logic signed [10:0] playerTopLeftX = '0;
    logic signed [10:0] playerTopLeftY = '0;
    logic               chain_trigger = 1'b0;
    logic signed [10:0] bombTopLeftX;
    logic signed [10:0] bombTopLeftY;
    logic               bomb_visible;
    logic               fuse_blink;
    logic               blast_active;
    logic               explode_pulse;
    logic               busy;

    bomb_drop_ctrl dut (
        .clk            (clk),
        .resetN         (resetN),
        .startOfFrame   (startOfFrame),
        .drop_bomb      (drop_bomb),
        .playerTopLeftX (playerTopLeftX),
        .playerTopLeftY (playerTopLeftY),
        .chain_trigger  (chain_trigger),
        .bombTopLeftX   (bombTopLeftX),
        .bombTopLeftY   (bombTopLeftY),
        .bomb_visible   (bomb_visible),
        .fuse_blink     (fuse_blink),
        .blast_active   (blast_active),
        .explode_pulse  (explode_pulse),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int n_expl = 0;

    // Reference model: frames elapsed since arm / since detonation.
    bit m_arm, m_blast, m_prev, m_expl;
    int m_el, m_bel, m_bx, m_by;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int snap(input int p, input int org, input int n);
        int v;
        int c;
        v = p + 16 - org;
        c = (v < 0) ? 0 : v / 32;
        if (c > n - 1) c = n - 1;
        return org + c * 32;
    endfunction

    task automatic model_reset();
        m_arm = 0; m_blast = 0; m_prev = 0; m_expl = 0;
        m_el = 0; m_bel = 0; m_bx = 0; m_by = 0;
    endtask

    task automatic model_step();
        bit edge_seen;
        if (!resetN) begin
            model_reset();
            return;
        end
        edge_seen = drop_bomb && !m_prev;
        m_expl = 0;
        if (m_blast) begin
            if (startOfFrame) begin
                m_bel++;
                if (m_bel == BLAST) m_blast = 0;
            end
        end else if (m_arm) begin
            if (startOfFrame) m_el++;
            if (chain_trigger || m_el == FUSE) begin
                m_arm = 0; m_blast = 1; m_bel = 0; m_expl = 1;
            end
        end else if (edge_seen) begin
            m_arm = 1;
            m_el = 0;
            m_bx = snap(int'(playerTopLeftX), 15, 19);
            m_by = snap(int'(playerTopLeftY), 48, 13);
        end
        m_prev = drop_bomb;
    endtask

    task automatic check_all();
        int rem;
        int blink;
        rem = FUSE - m_el;
        blink = (m_arm && rem <= BLINK && ((rem / 2) % 2) == 1) ? 1 : 0;
        chk("bomb_x", int'(bombTopLeftX), m_bx);
        chk("bomb_y", int'(bombTopLeftY), m_by);
        chk("visible", int'(bomb_visible), int'(m_arm));
        chk("blink", int'(fuse_blink), blink);
        chk("blast", int'(blast_active), int'(m_blast));
        chk("explode", int'(explode_pulse), int'(m_expl));
        chk("busy", int'(busy), int'(m_arm || m_blast));
        if (explode_pulse) n_expl++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            tick();
            startOfFrame = 1'b0;
            tick();
        end
    endtask

    task automatic place(input int x, input int y);
        playerTopLeftX = 11'(x);
        playerTopLeftY = 11'(y);
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_x", int'(bombTopLeftX), 0);
        resetN = 1'b1;
        tick();

        // Drop at the grid origin.
        place(15, 48);
        drop_bomb = 1'b1;
        tick();
        chk("t1_x", int'(bombTopLeftX), 15);
        chk("t1_y", int'(bombTopLeftY), 48);
        chk("t1_vis", int'(bomb_visible), 1);
        chk("t1_busy", int'(busy), 1);
        drop_bomb = 1'b0;

        // Full fuse then blast.
        n_expl = 0;
        frames(FUSE - 1);
        chk("t3_pre_blast", int'(blast_active), 0);
        frames(1);
        chk("t3_blast", int'(blast_active), 1);
        frames(BLAST - 1);
        chk("t3_still_blast", int'(blast_active), 1);
        frames(1);
        chk("t3_idle", int'(busy), 0);
        chk("t3_expl_cnt", n_expl, 1);

        // Snap and chain detonation.
        place(62, 100);
        drop_bomb = 1'b1;
        tick();
        drop_bomb = 1'b0;
        chk("t2_x", int'(bombTopLeftX), 47);
        chk("t2_y", int'(bombTopLeftY), 112);
        frames(10);
        chain_trigger = 1'b1;
        tick();
        chain_trigger = 1'b0;
        chk("t4_expl", int'(explode_pulse), 1);
        chk("t4_blast", int'(blast_active), 1);
        frames(BLAST + 1);

        place(600, 470);
        drop_bomb = 1'b1;
        tick();
        chk("t2c_x", int'(bombTopLeftX), 591);
        chk("t2c_y", int'(bombTopLeftY), 432);

        // Key held through fuse and blast: no re-arm.
        n_expl = 0;
        frames(FUSE + BLAST + 5);
        chk("t5_idle", int'(busy), 0);
        chk("t5_expl_cnt", n_expl, 1);
        drop_bomb = 1'b0;
        tick();
        drop_bomb = 1'b1;
        tick();
        chk("t5_rearm", int'(busy), 1);
        drop_bomb = 1'b0;

        // Asynchronous reset mid-fuse.
        frames(50);
        #2;
        resetN = 1'b0;
        #1;
        chk("t6_busy", int'(busy), 0);
        chk("t6_vis", int'(bomb_visible), 0);
        chk("t6_x", int'(bombTopLeftX), 0);
        model_reset();
        repeat (2) tick();
        resetN = 1'b1;
        n_expl = 0;
        frames(FUSE + 5);
        chk("t6_no_expl", n_expl, 0);

        // Random traffic.
        for (int i = 0; i < 6000; i++) begin
            startOfFrame   = ($urandom_range(3) == 0);
            chain_trigger  = ($urandom_range(299) == 0);
            if ($urandom_range(15) == 0) drop_bomb = ~drop_bomb;
            playerTopLeftX = 11'($urandom_range(1000) - 200);
            playerTopLeftY = 11'($urandom_range(800) - 200);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
